// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states and
// the MMIO register map.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] LED_OFS  = 8'h00;
  localparam logic [7:0] CYC_OFS  = 8'h04;
  localparam logic [7:0] STAT_OFS = 8'h08;

  localparam int STAT_MISALIGN_BIT = 0;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the processor and the data memory.
interface dmem_responder_if;

  logic        req;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;

  modport master (
    output req, memwrite, addr, writedata,
    input  readdata, ready
  );

  modport slave (
    input  req, memwrite, addr, writedata,
    output readdata, ready
  );

endinterface

// File: rtl/dmem_ram.sv
// Word-wide RAM with synchronous write and combinational read on one address.
module dmem_ram #(
  parameter  int DEPTH_WORDS = 64,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM plus LED/cycle-counter/status MMIO window, with a
// configurable number of wait states before ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus,
  output logic            misalign,
  output logic [7:0]      led
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  wcnt;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic        we_l;

  logic [31:0] cycles;
  logic        stat_mis;

  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_we;
  logic        fire;
  logic        is_mmio;
  logic        is_mis;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata;

  // With no wait states the access is served straight off the bus; otherwise
  // from the copy captured when the request was accepted.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      a_addr  = bus.addr;
      a_wdata = bus.writedata;
      a_we    = bus.memwrite;
      fire    = bus.req;
    end else begin
      a_addr  = addr_l;
      a_wdata = wdata_l;
      a_we    = we_l;
      fire    = (state == RESP);
    end
  end

  assign is_mmio = (a_addr[31:8] == MMIO_BASE[31:8]);
  assign is_mis  = (a_addr[1:0] != 2'b00);

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (fire & a_we & ~is_mmio & ~is_mis),
    .idx   (a_addr[AW+1:2]),
    .wdata (a_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    mmio_rdata = '0;
    case (a_addr[7:0])
      LED_OFS:  mmio_rdata = {24'h0, led};
      CYC_OFS:  mmio_rdata = cycles;
      STAT_OFS: mmio_rdata[STAT_MISALIGN_BIT] = stat_mis;
      default:  mmio_rdata = '0;
    endcase
  end

  assign bus.ready    = fire;
  assign bus.readdata = (fire && !is_mis) ? (is_mmio ? mmio_rdata : ram_rdata) : '0;
  assign misalign     = stat_mis;

  // MMIO registers; a misaligned access only sets the sticky bit, so set
  // always wins over a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles   <= '0;
      led      <= '0;
      stat_mis <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;
      if (fire) begin
        if (is_mis) begin
          stat_mis <= 1'b1;
        end else if (is_mmio && a_we) begin
          if (a_addr[7:0] == LED_OFS) led <= a_wdata[7:0];
          if (a_addr[7:0] == STAT_OFS && a_wdata[STAT_MISALIGN_BIT]) stat_mis <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else if (WAIT_CYCLES != 0) begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            state <= WAIT;
            wcnt  <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wcnt == 4'd0) state <= RESP;
          else              wcnt  <= wcnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      addr_l  <= bus.addr;
      wdata_l <= bus.writedata;
      we_l    <= bus.memwrite;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait and a three-wait instance side by side,
// directed vector table, reset-mid-access sequence, and randomized accesses.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int W1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mis0, mis1;
  logic [7:0] led0, led1;

  dmem_responder_if b0 ();
  dmem_responder_if b1 ();

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(rst_n), .bus(b0), .misalign(mis0), .led(led0)
  );
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W1)) u1 (
    .clk(clk), .reset(rst_n), .bus(b1), .misalign(mis1), .led(led1)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] mmem [2][64];
  logic [7:0]  mled [2];
  logic        mst  [2];

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    bit          crd;
    logic [31:0] erd;
    logic        emis;
    logic [7:0]  eled;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int d, logic we, logic [31:0] a, logic [31:0] wd,
                             bit crd, logic [31:0] erd, logic emis, logic [7:0] eled);
    vec_t r;
    r.d = d; r.we = we; r.a = a; r.wd = wd;
    r.crd = crd; r.erd = erd; r.emis = emis; r.eled = eled;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: word memory indexed modulo 64, LED byte, sticky misalign bit.
  function automatic logic [31:0] model(int d, logic we, logic [31:0] a, logic [31:0] wd);
    logic [31:0] r = '0;
    if (a[1:0] != 2'b00) begin
      mst[d] = 1'b1;
    end else if (a[31:8] == 24'hFFFFFF) begin
      if (a[7:0] == 8'h00) begin
        r = {24'h0, mled[d]};
        if (we) mled[d] = wd[7:0];
      end else if (a[7:0] == 8'h08) begin
        r = {31'h0, mst[d]};
        if (we && wd[0]) mst[d] = 1'b0;
      end
    end else begin
      r = mmem[d][(a / 4) % 64];
      if (we) mmem[d][(a / 4) % 64] = wd;
    end
    return r;
  endfunction

  function automatic logic get_rdy(int d);
    return (d == 0) ? b0.ready : b1.ready;
  endfunction

  function automatic logic [31:0] get_rd(int d);
    return (d == 0) ? b0.readdata : b1.readdata;
  endfunction

  task automatic drive(int d, logic rq, logic we, logic [31:0] a, logic [31:0] wd);
    if (d == 0) begin
      b0.req = rq; b0.memwrite = we; b0.addr = a; b0.writedata = wd;
    end else begin
      b1.req = rq; b1.memwrite = we; b1.addr = a; b1.writedata = wd;
    end
  endtask

  task automatic do_acc(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int zbad, output time tr);
    int n = 0;
    bit got = 0;
    rd = '0; lat = -1; zbad = 0; tr = 0;
    @(negedge clk);
    drive(d, 1'b1, we, a, wd);
    while (!got && n < 40) begin
      #1;
      if (get_rdy(d) === 1'b1) begin
        got = 1; rd = get_rd(d); lat = n; tr = $time;
      end else begin
        if (get_rd(d) !== 32'h0) zbad++;
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic run_acc(string nm, int d, logic we, logic [31:0] a, logic [31:0] wd,
                         bit crd, logic [31:0] erd, logic emis, logic [7:0] eled);
    logic [31:0] rd;
    int lat, zb;
    time tr;
    string tag;
    tag = $sformatf("%s_d%0d_a%h", nm, d, a);
    do_acc(d, we, a, wd, rd, lat, zb, tr);
    chk({tag, "_lat"}, lat, (d == 0) ? 0 : W1 + 1);
    if (d == 1) chk({tag, "_rd_zero_when_idle"}, zb, 0);
    if (crd) chk({tag, "_rd"}, rd, erd);
    chk({tag, "_misalign"}, (d == 0) ? mis0 : mis1, emis);
    chk({tag, "_led"}, (d == 0) ? led0 : led1, eled);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, c1, c2, a, wd, exp;
    int lat, zb, k, d;
    time t1, t2;
    logic we;

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin mled[i] = 8'h0; mst[i] = 1'b0; end

    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready0", b0.ready, 0);
    chk("reset_ready1", b1.ready, 0);
    chk("reset_rd0", b0.readdata, 0);
    chk("reset_rd1", b1.readdata, 0);
    chk("reset_led0", led0, 0);
    chk("reset_led1", led1, 0);
    chk("reset_mis0", mis0, 0);
    chk("reset_mis1", mis1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int dd = 0; dd < 2; dd++) begin
      tbl.push_back(v(dd, 1, 32'h10,       32'hDEADBEEF, 0, 0,            0, 8'h00));
      tbl.push_back(v(dd, 0, 32'h10,       0,            1, 32'hDEADBEEF, 0, 8'h00));
      tbl.push_back(v(dd, 1, 32'h100,      32'h12345678, 0, 0,            0, 8'h00));
      tbl.push_back(v(dd, 0, 32'h000,      0,            1, 32'h12345678, 0, 8'h00));
      tbl.push_back(v(dd, 0, 32'h10,       0,            1, 32'hDEADBEEF, 0, 8'h00));
      tbl.push_back(v(dd, 1, 32'hFFFFFF00, 32'h000001A5, 0, 0,            0, 8'hA5));
      tbl.push_back(v(dd, 0, 32'hFFFFFF00, 0,            1, 32'h000000A5, 0, 8'hA5));
      tbl.push_back(v(dd, 0, 32'hFFFFFF0C, 0,            1, 32'h0,        0, 8'hA5));
      tbl.push_back(v(dd, 1, 32'hFFFFFF04, 32'hFFFFFFFF, 0, 0,            0, 8'hA5));
      tbl.push_back(v(dd, 1, 32'h13,       32'h55555555, 0, 0,            1, 8'hA5));
      tbl.push_back(v(dd, 0, 32'h10,       0,            1, 32'hDEADBEEF, 1, 8'hA5));
      tbl.push_back(v(dd, 0, 32'h13,       0,            1, 32'h0,        1, 8'hA5));
      tbl.push_back(v(dd, 0, 32'hFFFFFF08, 0,            1, 32'h1,        1, 8'hA5));
      tbl.push_back(v(dd, 1, 32'hFFFFFF08, 32'h0,        0, 0,            1, 8'hA5));
      tbl.push_back(v(dd, 1, 32'hFFFFFF08, 32'h1,        0, 0,            0, 8'hA5));
      tbl.push_back(v(dd, 0, 32'hFFFFFF08, 0,            1, 32'h0,        0, 8'hA5));
      tbl.push_back(v(dd, 1, 32'h20,       32'h11112222, 0, 0,            0, 8'hA5));
      tbl.push_back(v(dd, 1, 32'hFFFFFF20, 32'h000000FF, 0, 0,            0, 8'hA5));
    end
    foreach (tbl[i]) begin
      void'(model(tbl[i].d, tbl[i].we, tbl[i].a, tbl[i].wd));
      run_acc("vec", tbl[i].d, tbl[i].we, tbl[i].a, tbl[i].wd,
              tbl[i].crd, tbl[i].erd, tbl[i].emis, tbl[i].eled);
    end

    // Cycle counter advances by one per clock between two reads.
    for (int dd = 0; dd < 2; dd++) begin
      do_acc(dd, 1'b0, 32'hFFFFFF04, 32'h0, c1, lat, zb, t1);
      repeat (7) @(posedge clk);
      do_acc(dd, 1'b0, 32'hFFFFFF04, 32'h0, c2, lat, zb, t2);
      chk($sformatf("cycles_delta_d%0d", dd), c2 - c1, 32'((t2 - t1) / 10));
    end

    // Reset in the middle of a waited store: outputs clear at once, store dropped.
    void'(model(1, 1'b0, 32'h21, 32'h0));
    run_acc("mis_pre", 1, 1'b0, 32'h21, 32'h0, 1, 32'h0, 1, 8'hA5);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h20, 32'hCAFE0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", b1.ready, 0);
    chk("rst_mid_rd", b1.readdata, 0);
    chk("rst_mid_led1", led1, 0);
    chk("rst_mid_led0", led0, 0);
    chk("rst_mid_mis1", mis1, 0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin mled[i] = 8'h0; mst[i] = 1'b0; end
    run_acc("rst_after", 1, 1'b0, 32'h20, 32'h0, 1, 32'h11112222, 0, 8'h00);
    run_acc("rst_after", 0, 1'b0, 32'h20, 32'h0, 1, 32'h11112222, 0, 8'h00);

    // Fill RAM so every model word is known, then random traffic.
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < 64; i++) begin
        wd = $urandom;
        void'(model(dd, 1'b1, 32'(i * 4), wd));
        run_acc("fill", dd, 1'b1, 32'(i * 4), wd, 0, 0, mst[dd], mled[dd]);
      end
    end

    for (int n = 0; n < 200; n++) begin
      d  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      a  = $urandom;
      k  = $urandom_range(0, 9);
      if (k <= 5) begin
        a[1:0] = 2'b00;
        if (a[31:8] == 24'hFFFFFF) a[31] = 1'b0;
      end else if (k == 6) begin
        if (a[1:0] == 2'b00) a[0] = 1'b1;
      end else if (k == 7) begin
        a = 32'hFFFFFF00;
      end else if (k == 8) begin
        a = 32'hFFFFFF08;
      end else begin
        a = 32'hFFFFFF00 | 32'(8'h0C + 4 * $urandom_range(0, 60));
        if (we && a[4]) a = 32'hFFFFFF04;
      end
      exp = model(d, we, a, wd);
      run_acc("rnd", d, we, a, wd, !we, exp, mst[d], mled[d]);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the processor's load/store port.
- Accepts an address, write strobe and write data. Returns read data and a ready handshake after a configurable number of wait states, so stall support can be exercised.
- Contains a word-addressed RAM plus a small memory-mapped I/O window: LED register, free-running cycle counter and sticky status register.
- Instantiated beside the processor in the top level, driven by its memwrite, aluout (as address) and writedata outputs; it drives readdata.

Parameters:
- DEPTH_WORDS, 64, RAM size in 32-bit words; power of two, at least 2.
- WAIT_CYCLES, 0, extra cycles between request acceptance and ready; 0 to 15.
- MMIO_BASE, 32'hFFFF_FF00, base of the I/O window; the low 8 bits are zero.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access valid; held with addr/memwrite/writedata stable until ready.
- memwrite  in  1  1 = store, 0 = load.
- addr  in  32  byte address (processor aluout).
- writedata  in  32  store data.
- readdata  out  32  load data; valid only while ready=1, otherwise 0.
- ready  out  1  access completes this cycle.
- misalign  out  1  mirror of sticky status bit 0.
- led  out  8  LED register.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, ready=0, readdata=0, led=0, cycle counter=0, status=0, wait counter=0. RAM contents are not reset.
- Reset asserted mid-access aborts it; a pending store is dropped.
- Address decode:
  - addr[31:8]==MMIO_BASE[31:8] selects MMIO, else RAM.
  - RAM index = addr[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so addresses alias modulo DEPTH_WORDS.
- MMIO map:
  - +0x00 LED: R/W, bits 7:0, upper bits read 0.
  - +0x04 CYCLES: read-only 32-bit counter, +1 every cycle, wraps at 2^32; writes ignored.
  - +0x08 STATUS: bit0 = sticky misalign; writing bit0=1 clears it.
  - Other offsets: read 0, writes ignored.
- Misalignment: addr[1:0]!=0 means no RAM/MMIO side effect, readdata=0, ready is still returned on schedule, and STATUS[0] is set at the completing edge.
  - If a clear and a new misalign coincide, set wins.
- WAIT_CYCLES=0:
  - ready = req, combinational, in the same cycle.
  - Load data is combinational from the RAM/MMIO at the current addr.
  - Store commits at the rising edge where req&ready.
  - The FSM stays in IDLE.
- WAIT_CYCLES>0, FSM:
  - IDLE: when req=1, latch addr/memwrite/writedata, load wait counter with WAIT_CYCLES-1, go to WAIT. ready=0.
  - WAIT: decrement the counter; at 0 go to RESP. ready=0.
  - RESP: ready=1 for exactly one cycle. readdata comes from the latched address. A store commits at this edge. Then go to IDLE.
  - Total latency: ready in cycle WAIT_CYCLES+1 after the req cycle.
  - req dropping during WAIT is ignored; the latched access completes.
  - Back-to-back: a req still high in the cycle after RESP starts a new access; there is no extra bubble beyond IDLE.
- CYCLES read value is the counter value in the ready cycle.
- Load from a just-stored location returns the new data: the store happens at the earlier edge.
- Mixed-width behaviour: none. Word accesses only; no byte lanes.

Decomposition:
- Shared package dmem_pkg:
  - FSM state enum (IDLE, WAIT, RESP).
  - MMIO offset constants (LED_OFS=8'h00, CYC_OFS=8'h04, STAT_OFS=8'h08).
  - STAT_MISALIGN_BIT=0.
- Sub-module dmem_ram: DEPTH_WORDS x 32 array with synchronous write and combinational read.
- MMIO regs and the FSM live in the top.

Test Plan:
- WAIT_CYCLES=0: store 32'hDEADBEEF @ 0x10, then load 0x10 -> ready same cycle, readdata=32'hDEADBEEF.
- WAIT_CYCLES=3: load 0x10 with req held -> ready exactly 4 cycles after req rose, high one cycle, readdata=32'hDEADBEEF; readdata=0 in the other cycles.
- Alias with DEPTH_WORDS=64: store 32'h1234_5678 @ 0x100, load 0x000 -> 32'h1234_5678.
- MMIO: store 32'h0000_01A5 @ 0xFFFFFF00 -> led=8'hA5; load back -> 32'h000000A5. Two CYCLES loads N cycles apart differ by N.
- Misalign: store @ 0x13 -> ready given, RAM word 0x10 unchanged, misalign=1. Store 1 @ 0xFFFFFF08 -> misalign=0.
- Reset mid-WAIT (WAIT_CYCLES=3, store 32'hCAFE0000 @ 0x20, reset low in WAIT) -> ready=0, led=0 immediately. After release, load 0x20 returns the old contents.
